// File: rtl/arm_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// arm_ctrl_pkg
// Shared types and encodings for the multicycle ARM control unit:
//   - state_t      : FSM states of the instruction sequencer
//   - ALU_*        : ALUControl encodings
//   - RES_*        : ResultSrc encodings
//   - SRCB_*       : ALUSrcB encodings
//   - IMM_*        : ImmSrc encodings
//   - OP_*, CMD_*  : instruction op / cmd field values
//   - COND_*       : condition-code field values
//   - cond_holds() : ARM condition table evaluated against NZCV
// -----------------------------------------------------------------------------
package arm_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH,
      S_DECODE,
      S_MEMADR,
      S_MEMREAD,
      S_MEMWB,
      S_MEMWRITE,
      S_EXECUTER,
      S_EXECUTEI,
      S_ALUWB,
      S_BRANCH
   } state_t;

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;
   localparam logic [1:0] ALU_AND = 2'b10;
   localparam logic [1:0] ALU_ORR = 2'b11;

   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_READDATA  = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   localparam logic [1:0] SRCB_RD2    = 2'b00;
   localparam logic [1:0] SRCB_EXTIMM = 2'b01;
   localparam logic [1:0] SRCB_FOUR   = 2'b10;

   localparam logic [1:0] IMM_DP8   = 2'b00;
   localparam logic [1:0] IMM_MEM12 = 2'b01;
   localparam logic [1:0] IMM_BR24  = 2'b10;

   localparam logic [1:0] OP_DP  = 2'b00;
   localparam logic [1:0] OP_MEM = 2'b01;
   localparam logic [1:0] OP_BR  = 2'b10;

   localparam logic [3:0] CMD_AND = 4'b0000;
   localparam logic [3:0] CMD_SUB = 4'b0010;
   localparam logic [3:0] CMD_ADD = 4'b0100;
   localparam logic [3:0] CMD_CMP = 4'b1010;
   localparam logic [3:0] CMD_ORR = 4'b1100;

   localparam logic [3:0] COND_EQ = 4'b0000;
   localparam logic [3:0] COND_NE = 4'b0001;
   localparam logic [3:0] COND_CS = 4'b0010;
   localparam logic [3:0] COND_CC = 4'b0011;
   localparam logic [3:0] COND_MI = 4'b0100;
   localparam logic [3:0] COND_PL = 4'b0101;
   localparam logic [3:0] COND_VS = 4'b0110;
   localparam logic [3:0] COND_VC = 4'b0111;
   localparam logic [3:0] COND_HI = 4'b1000;
   localparam logic [3:0] COND_LS = 4'b1001;
   localparam logic [3:0] COND_GE = 4'b1010;
   localparam logic [3:0] COND_LT = 4'b1011;
   localparam logic [3:0] COND_GT = 4'b1100;
   localparam logic [3:0] COND_LE = 4'b1101;
   localparam logic [3:0] COND_AL = 4'b1110;

   // flags = {N,Z,C,V}. The reserved code 1111 never executes.
   function automatic logic cond_holds(input logic [3:0] cond, input logic [3:0] flags);
      logic n, z, c, v;
      {n, z, c, v} = flags;
      case (cond)
         COND_EQ: return z;
         COND_NE: return ~z;
         COND_CS: return c;
         COND_CC: return ~c;
         COND_MI: return n;
         COND_PL: return ~n;
         COND_VS: return v;
         COND_VC: return ~v;
         COND_HI: return c & ~z;
         COND_LS: return ~c | z;
         COND_GE: return n == v;
         COND_LT: return n != v;
         COND_GT: return ~z & (n == v);
         COND_LE: return z | (n != v);
         COND_AL: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/multicycle_control_unit_cond_logic.sv
// -----------------------------------------------------------------------------
// cond_logic
// Architectural NZCV register plus the per-instruction condition latch.
// Build option: ARM_COND_EXEC_EN -- when defined the condition table is
// evaluated in DECODE and latched into cond_ex_r; when undefined every
// instruction executes (cond_ex_r tied to 1) and no condition logic exists.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   cond         : Instr[31:28] of the current instruction
//   cond_latch   : capture the condition result (DECODE)
//   alu_flags    : {N,Z,C,V} from the ALU
//   flag_req     : an S-setting execute cycle is ending
//   cv_update    : the ALU op is ADD/SUB, so C and V are meaningful
//   flags        : current NZCV register
//   cond_ex_r    : latched "this instruction executes"
// -----------------------------------------------------------------------------
module cond_logic
   import arm_ctrl_pkg::*;
#(
   parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] cond,
   input  logic       cond_latch,
   input  logic [3:0] alu_flags,
   input  logic       flag_req,
   input  logic       cv_update,
   output logic [3:0] flags,
   output logic       cond_ex_r
);

   // NOTE: sequential state is only ever assigned with <= so every register
   // samples the pre-edge values, independent of process ordering.
   always_ff @(posedge clk) begin
      if (reset) begin
         flags <= RESET_FLAGS;
      end else if (flag_req && cond_ex_r) begin
         flags[3:2] <= alu_flags[3:2];
         if (cv_update) flags[1:0] <= alu_flags[1:0];
      end
   end

`ifdef ARM_COND_EXEC_EN
   always_ff @(posedge clk) begin
      if (reset)           cond_ex_r <= 1'b0;
      else if (cond_latch) cond_ex_r <= cond_holds(cond, flags);
   end
`else
   assign cond_ex_r = 1'b1;

   logic unused_cond;
   assign unused_cond = ^{cond, cond_latch};
`endif

endmodule

// File: rtl/multicycle_control_unit.sv
// -----------------------------------------------------------------------------
// multicycle_control_unit
// Sequencer for the multicycle ARM core: FETCH/DECODE/EXECUTE/WRITEBACK FSM,
// cmd decode, and the NZCV / condition unit (cond_logic).
// Build option: ARM_COND_EXEC_EN (see cond_logic).
// Ports:
//   CLK, RESET   : clock, synchronous active-high reset
//   Instr        : latched instruction
//   ALUFlags     : {N,Z,C,V} from the ALU
//   PCWrite, IRWrite, RegWrite, MemWrite : datapath write enables
//   AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, RegSrc, ALUControl : selects
//   Flags        : current NZCV register
// -----------------------------------------------------------------------------
module multicycle_control_unit
   import arm_ctrl_pkg::*;
#(
   parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic [31:0] Instr,
   input  logic [3:0]  ALUFlags,
   output logic        PCWrite,
   output logic        IRWrite,
   output logic        RegWrite,
   output logic        MemWrite,
   output logic        AdrSrc,
   output logic [1:0]  ResultSrc,
   output logic        ALUSrcA,
   output logic [1:0]  ALUSrcB,
   output logic [1:0]  ImmSrc,
   output logic [1:0]  RegSrc,
   output logic [1:0]  ALUControl,
   output logic [3:0]  Flags
);

   logic [3:0] cond, cmd, rd;
   logic [1:0] op;
   logic       i_bit, s_bit;

   assign cond  = Instr[31:28];
   assign op    = Instr[27:26];
   assign i_bit = Instr[25];
   assign cmd   = Instr[24:21];
   assign s_bit = Instr[20];
   assign rd    = Instr[15:12];

   logic unused_instr_bits;
   assign unused_instr_bits = ^{Instr[19:16], Instr[11:0]};

   // cmd decode: CMP and unsupported commands never write Rd; CMP always sets flags.
   logic [1:0] dp_alu;
   logic       no_write, s_eff;

   always_comb begin
      dp_alu   = ALU_ADD;
      no_write = 1'b0;
      s_eff    = s_bit;
      case (cmd)
         CMD_ADD: dp_alu = ALU_ADD;
         CMD_SUB: dp_alu = ALU_SUB;
         CMD_AND: dp_alu = ALU_AND;
         CMD_ORR: dp_alu = ALU_ORR;
         CMD_CMP: begin
            dp_alu   = ALU_SUB;
            no_write = 1'b1;
            s_eff    = 1'b1;
         end
         default: no_write = 1'b1;
      endcase
   end

   state_t state, state_next;
   logic   cond_ex_r;
   logic   executing;

   assign executing = (state == S_EXECUTER) || (state == S_EXECUTEI);

   cond_logic #(.RESET_FLAGS(RESET_FLAGS)) u_cond (
      .clk        (CLK),
      .reset      (RESET),
      .cond       (cond),
      .cond_latch (state == S_DECODE),
      .alu_flags  (ALUFlags),
      .flag_req   (executing && s_eff),
      .cv_update  ((dp_alu == ALU_ADD) || (dp_alu == ALU_SUB)),
      .flags      (Flags),
      .cond_ex_r  (cond_ex_r)
   );

   always_ff @(posedge CLK) begin
      if (RESET) state <= S_FETCH;
      else       state <= state_next;
   end

   // NOTE: every output and state_next gets a default before the case so no
   // path leaves a variable unassigned, which would infer a latch.
   always_comb begin
      state_next = state;
      PCWrite    = 1'b0;
      IRWrite    = 1'b0;
      RegWrite   = 1'b0;
      MemWrite   = 1'b0;
      AdrSrc     = 1'b0;
      ResultSrc  = RES_ALUOUT;
      ALUSrcA    = 1'b0;
      ALUSrcB    = SRCB_RD2;
      ImmSrc     = IMM_DP8;
      RegSrc     = 2'b00;
      ALUControl = ALU_ADD;

      case (state)
         S_FETCH: begin
            IRWrite    = 1'b1;
            PCWrite    = 1'b1;
            ALUSrcA    = 1'b1;
            ALUSrcB    = SRCB_FOUR;
            ResultSrc  = RES_ALURESULT;
            state_next = S_DECODE;
         end
         S_DECODE: begin
            ALUSrcA   = 1'b1;
            ALUSrcB   = SRCB_FOUR;
            ResultSrc = RES_ALURESULT;
            case (op)
               OP_MEM:  state_next = S_MEMADR;
               OP_DP:   state_next = i_bit ? S_EXECUTEI : S_EXECUTER;
               OP_BR:   state_next = S_BRANCH;
               default: state_next = S_FETCH;
            endcase
         end
         S_MEMADR: begin
            ALUSrcB    = SRCB_EXTIMM;
            ImmSrc     = IMM_MEM12;
            state_next = s_bit ? S_MEMREAD : S_MEMWRITE;
         end
         S_MEMREAD: begin
            AdrSrc     = 1'b1;
            state_next = S_MEMWB;
         end
         S_MEMWB: begin
            ResultSrc  = RES_READDATA;
            RegWrite   = cond_ex_r;
            state_next = S_FETCH;
         end
         S_MEMWRITE: begin
            AdrSrc     = 1'b1;
            RegSrc     = 2'b10;
            MemWrite   = cond_ex_r;
            state_next = S_FETCH;
         end
         S_EXECUTER: begin
            ALUSrcB    = SRCB_RD2;
            ALUControl = dp_alu;
            state_next = S_ALUWB;
         end
         S_EXECUTEI: begin
            ALUSrcB    = SRCB_EXTIMM;
            ImmSrc     = IMM_DP8;
            ALUControl = dp_alu;
            state_next = S_ALUWB;
         end
         S_ALUWB: begin
            ResultSrc  = RES_ALUOUT;
            RegWrite   = cond_ex_r & ~no_write;
            PCWrite    = cond_ex_r & ~no_write & (rd == 4'd15);
            state_next = S_FETCH;
         end
         S_BRANCH: begin
            RegSrc     = 2'b01;
            ALUSrcB    = SRCB_EXTIMM;
            ImmSrc     = IMM_BR24;
            ResultSrc  = RES_ALURESULT;
            PCWrite    = cond_ex_r;
            state_next = S_FETCH;
         end
         default: state_next = S_FETCH;
      endcase

      // A reset cycle must never commit anything, whatever state it lands in.
      if (RESET) begin
         PCWrite  = 1'b0;
         IRWrite  = 1'b0;
         RegWrite = 1'b0;
         MemWrite = 1'b0;
      end
   end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control_unit
// Directed instructions followed by random ones. An instruction-level model
// produces the expected per-cycle control vector and tracks NZCV.
// -----------------------------------------------------------------------------
module tb_multicycle_control_unit;

   logic        CLK = 1'b0;
   logic        RESET = 1'b1;
   logic [31:0] Instr = 32'h0;
   logic [3:0]  ALUFlags = 4'h0;
   logic        PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA;
   logic [1:0]  ResultSrc, ALUSrcB, ImmSrc, RegSrc, ALUControl;
   logic [3:0]  Flags;

   always #5 CLK = ~CLK;

   multicycle_control_unit #(.RESET_FLAGS(4'b0000)) dut (
      .CLK(CLK), .RESET(RESET), .Instr(Instr), .ALUFlags(ALUFlags),
      .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .MemWrite(MemWrite),
      .AdrSrc(AdrSrc), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
      .ImmSrc(ImmSrc), .RegSrc(RegSrc), .ALUControl(ALUControl), .Flags(Flags)
   );

   int          n_vec = 0;
   int          n_err = 0;
   logic [3:0]  mflags = 4'b0000;

   wire [15:0] dut_vec = {PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ResultSrc,
                          ALUSrcA, ALUSrcB, ImmSrc, RegSrc, ALUControl};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [15:0] mk(input logic pcw, input logic irw, input logic rw,
                                      input logic mw, input logic adr, input logic [1:0] rs,
                                      input logic asa, input logic [1:0] asb,
                                      input logic [1:0] imm, input logic [1:0] rsrc,
                                      input logic [1:0] alu);
      return {pcw, irw, rw, mw, adr, rs, asa, asb, imm, rsrc, alu};
   endfunction

   // Conditions come in complementary pairs: cond[3:1] picks the base test,
   // cond[0] inverts it. 1110 always, 1111 never.
   function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
      logic n, z, cy, v, base;
      {n, z, cy, v} = f;
      case (c[3:1])
         3'd0:    base = z;
         3'd1:    base = cy;
         3'd2:    base = n;
         3'd3:    base = v;
         3'd4:    base = cy & ~z;
         3'd5:    base = (n == v);
         3'd6:    base = ~z & (n == v);
         default: base = 1'b1;
      endcase
`ifdef ARM_COND_EXEC_EN
      if (c == 4'hF) return 1'b0;
      return base ^ c[0];
`else
      return 1'b1;
`endif
   endfunction

   task automatic cycle(input string tag, input logic [31:0] ins, input logic [3:0] af,
                        input logic [15:0] exp);
      @(negedge CLK);
      RESET    = 1'b0;
      Instr    = ins;
      ALUFlags = af;
      #1;
      check({tag, " ctrl"}, {16'h0, dut_vec}, {16'h0, exp});
      check({tag, " flags"}, {28'h0, Flags}, {28'h0, mflags});
   endtask

   task automatic do_reset(input int ncyc);
      for (int k = 0; k < ncyc; k++) begin
         @(negedge CLK);
         RESET = 1'b1;
         #1;
         check("reset enables", {28'h0, PCWrite, IRWrite, RegWrite, MemWrite}, 32'h0);
         if (k > 0) check("reset flags", {28'h0, Flags}, 32'h0);
      end
      mflags = 4'b0000;
   endtask

   task automatic run_instr(input logic [31:0] ins, input logic force_af, input logic [3:0] af_val);
      logic [3:0] cond, cmd, rd, af;
      logic [1:0] op, alu;
      logic       i_b, s_b, ce, nw, seff;
      cond = ins[31:28]; op = ins[27:26]; i_b = ins[25]; cmd = ins[24:21];
      s_b = ins[20]; rd = ins[15:12];
      af = force_af ? af_val : 4'($urandom);
      ce = cond_ok(cond, mflags);
      nw = 1'b0; seff = s_b;
      if      (cmd == 4'b0100) alu = 2'b00;
      else if (cmd == 4'b0010) alu = 2'b01;
      else if (cmd == 4'b0000) alu = 2'b10;
      else if (cmd == 4'b1100) alu = 2'b11;
      else if (cmd == 4'b1010) begin alu = 2'b01; nw = 1'b1; seff = 1'b1; end
      else begin alu = 2'b00; nw = 1'b1; end

      cycle("FETCH",  ins, af, mk(1, 1, 0, 0, 0, 2'd2, 1, 2'd2, 2'd0, 2'd0, 2'd0));
      cycle("DECODE", ins, af, mk(0, 0, 0, 0, 0, 2'd2, 1, 2'd2, 2'd0, 2'd0, 2'd0));
      case (op)
         2'b01: begin
            cycle("MEMADR", ins, af, mk(0, 0, 0, 0, 0, 2'd0, 0, 2'd1, 2'd1, 2'd0, 2'd0));
            if (s_b) begin
               cycle("MEMREAD", ins, af, mk(0, 0, 0, 0, 1, 2'd0, 0, 2'd0, 2'd0, 2'd0, 2'd0));
               cycle("MEMWB",   ins, af, mk(0, 0, ce, 0, 0, 2'd1, 0, 2'd0, 2'd0, 2'd0, 2'd0));
            end else begin
               cycle("MEMWRITE", ins, af, mk(0, 0, 0, ce, 1, 2'd0, 0, 2'd0, 2'd0, 2'd2, 2'd0));
            end
         end
         2'b00: begin
            if (i_b) cycle("EXECUTEI", ins, af, mk(0, 0, 0, 0, 0, 2'd0, 0, 2'd1, 2'd0, 2'd0, alu));
            else     cycle("EXECUTER", ins, af, mk(0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, 2'd0, alu));
            if (seff && ce) begin
               mflags[3:2] = af[3:2];
               if (alu == 2'b00 || alu == 2'b01) mflags[1:0] = af[1:0];
            end
            cycle("ALUWB", ins, af, mk(ce & ~nw & (rd == 4'd15), 0, ce & ~nw, 0, 0, 2'd0,
                                       0, 2'd0, 2'd0, 2'd0, 2'd0));
         end
         2'b10: cycle("BRANCH", ins, af, mk(ce, 0, 0, 0, 0, 2'd2, 0, 2'd1, 2'd2, 2'd1, 2'd0));
         default: ;
      endcase
   endtask

   initial begin
      do_reset(2);

      run_instr(32'hE0821003, 1'b1, 4'b1111);   // ADD R1,R2,R3 : flags untouched
      run_instr(32'hE0500000, 1'b1, 4'b0100);   // SUBS -> Z set
      run_instr(32'h0A000002, 1'b0, 4'h0);      // BEQ taken
      run_instr(32'hE0500000, 1'b1, 4'b0000);   // SUBS -> Z clear
      run_instr(32'h0A000002, 1'b0, 4'h0);      // BEQ not taken
      run_instr(32'hE5954008, 1'b0, 4'h0);      // LDR R4,[R5,#8]
      run_instr(32'hE5854008, 1'b0, 4'h0);      // STR
      run_instr(32'hF0821003, 1'b0, 4'h0);      // cond 1111
      run_instr(32'hE1500000, 1'b1, 4'b1010);   // CMP: flags, no write
      run_instr(32'hE0108000, 1'b1, 4'b0101);   // ANDS: NZ only, CV kept
      run_instr(32'hE080F002, 1'b0, 4'h0);      // ADD PC,... : PCWrite in ALUWB
      run_instr(32'hEC000000, 1'b0, 4'h0);      // undefined op: back to FETCH

      // Reset in the middle of an LDR (during MEMADR) after flags were set.
      run_instr(32'hE0500000, 1'b1, 4'b1011);
      cycle("FETCH", 32'hE5954008, 4'h0, mk(1, 1, 0, 0, 0, 2'd2, 1, 2'd2, 2'd0, 2'd0, 2'd0));
      cycle("DECODE", 32'hE5954008, 4'h0, mk(0, 0, 0, 0, 0, 2'd2, 1, 2'd2, 2'd0, 2'd0, 2'd0));
      do_reset(2);
      run_instr(32'hE5954008, 1'b0, 4'h0);

      for (int k = 0; k < 80; k++) begin
         logic [31:0] ins;
         logic [3:0]  cnd;
         cnd = ($urandom_range(0, 1) == 0) ? 4'hE : 4'($urandom);
         ins = {cnd, 2'($urandom), 1'($urandom), 4'($urandom), 1'($urandom),
                4'($urandom), 4'($urandom), 12'($urandom)};
         run_instr(ins, 1'b0, 4'h0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
